pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32IM pipeline. It detects load-use hazards and taken-branch flushes, holds the pipeline for the multi-cycle divide unit, and freezes on data-memory wait. It drives per-stage register enables and flush/bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipeline_hazard_controller.sv | 130 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: load-use, taken branch, multi-cycle divide and dmem wait.
// Define HAZ_PERF_CNT_EN to build the stall_cycles performance counter; otherwise it is tied to zero.
module pipeline_hazard_controller #(
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned MEM_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_is_div,
  input  logic        ex_branch_taken,
  input  logic        dmem_busy,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_bubble,
  output logic        div_busy,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, DIV_WAIT, MEM_WAIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  div_cnt, div_cnt_nxt;
  logic [15:0] mem_cnt, mem_cnt_nxt;
  logic        mem_timeout_nxt;
  logic        load_use;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      div_cnt     <= '0;
      mem_cnt     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      div_cnt     <= div_cnt_nxt;
      mem_cnt     <= mem_cnt_nxt;
      mem_timeout <= mem_timeout_nxt;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt       = state;
    div_cnt_nxt     = div_cnt;
    mem_cnt_nxt     = '0;
    mem_timeout_nxt = mem_timeout;
    if (dmem_busy) begin
      mem_cnt_nxt = (mem_cnt == 16'hFFFF) ? mem_cnt : mem_cnt + 16'd1;
      if (mem_cnt == 16'(MEM_TIMEOUT - 1)) mem_timeout_nxt = 1'b1;
    end
    case (state)
      DIV_WAIT: begin
        if (!dmem_busy) begin
          if (div_cnt != 8'd0) div_cnt_nxt = div_cnt - 8'd1;
          else                 state_nxt   = RUN;
        end
      end
      default: begin
        if (dmem_busy) begin
          state_nxt = MEM_WAIT;
        end else if (ex_is_div) begin
          state_nxt   = DIV_WAIT;
          div_cnt_nxt = 8'(DIV_CYCLES - 1);
        end else begin
          state_nxt = RUN;
        end
      end
    endcase
  end

  // Reset forces the free-running "no hazard" row regardless of inputs.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    div_busy      = 1'b0;
    if (!reset) begin
      div_busy = (state == DIV_WAIT);
      if (dmem_busy) begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      end else if (state == DIV_WAIT) begin
        if (div_cnt != 8'd0) begin
          {pc_en, if_id_en, id_ex_en} = 3'b000;
          ex_mem_bubble = 1'b1;
        end
      end else if (ex_is_div) begin
        {pc_en, if_id_en, id_ex_en} = 3'b000;
        ex_mem_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       stall_cycles <= '0;
    else if (!pc_en) stall_cycles <= stall_cycles + 32'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with DIV_CYCLES=4, MEM_TIMEOUT=8.
// Expected stall_cycles tracks HAZ_PERF_CNT_EN the same way the design build does.
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_div, ex_branch_taken, dmem_busy;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_bubble, div_busy, mem_timeout;
  logic [31:0] stall_cycles;
  logic [8:0]  obs;

  int nvec = 0;
  int nerr = 0;
  int exp_stall = 0;

  // Output row order: pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush, id_ex_flush, bubble, div_busy
  localparam logic [8:0] RUNR = 9'b111110000;
  localparam logic [8:0] FRZ  = 9'b000000000;
  localparam logic [8:0] FRZD = 9'b000000001;
  localparam logic [8:0] LU   = 9'b001110100;
  localparam logic [8:0] BR   = 9'b111111100;
  localparam logic [8:0] DIVS = 9'b000110010;
  localparam logic [8:0] DIVW = 9'b000110011;
  localparam logic [8:0] REL  = 9'b111110001;

  always #5 clk = ~clk;

  assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_bubble, div_busy};

  pipeline_hazard_controller #(.DIV_CYCLES(4), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_is_div(ex_is_div),
    .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble), .div_busy(div_busy), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  function automatic logic [31:0] exp_sc();
`ifdef HAZ_PERF_CNT_EN
    return 32'(exp_stall);
`else
    return 32'd0;
`endif
  endfunction

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_div, ex_branch_taken, dmem_busy} = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    dmem_busy = 1'b1;
    ex_is_div = 1'b1;
    #2;
    nvec++;
    if (obs !== RUNR) begin nerr++; $display("FAIL reset_row: got %b want %b", obs, RUNR); end
    nvec++;
    if (mem_timeout !== 1'b0) begin nerr++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
    nvec++;
    if (stall_cycles !== 32'd0) begin nerr++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    edge_step();
    clear_inputs();
    reset = 1'b0;
    #1;
    nvec++;
    if (obs !== RUNR) begin nerr++; $display("FAIL post_reset_row: got %b want %b", obs, RUNR); end
    edge_step();
  endtask

  task automatic test_load_use();
    // {mem_read, rd, rs1, rs2, uses_rs1, uses_rs2}
    logic [17:0] stim [0:5];
    logic [8:0]  exp  [0:5];
    stim = '{{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0},
             {1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0},
             {1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1},
             {1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1},
             {1'b1, 5'd5, 5'd5, 5'd3, 1'b0, 1'b1},
             {1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1}};
    exp  = '{LU, RUNR, LU, RUNR, RUNR, RUNR};
    for (int i = 0; i < 6; i++) begin
      {ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2} = stim[i];
      #1;
      nvec++;
      if (obs !== exp[i]) begin nerr++; $display("FAIL load_use[%0d]: got %b want %b", i, obs, exp[i]); end
      if (!exp[i][8]) exp_stall++;
      edge_step();
    end
    clear_inputs();
    nvec++;
    if (stall_cycles !== exp_sc()) begin nerr++; $display("FAIL load_use_stalls: got %0d want %0d", stall_cycles, exp_sc()); end
  endtask

  task automatic test_branch();
    // {branch, load_use_present, dmem_busy}
    logic [2:0] stim [0:3];
    logic [8:0] exp  [0:3];
    stim = '{3'b110, 3'b100, 3'b111, 3'b110};
    exp  = '{BR, BR, FRZ, BR};
    ex_rd = 5'd9; id_rs1 = 5'd9;
    for (int i = 0; i < 4; i++) begin
      ex_branch_taken = stim[i][2];
      ex_mem_read     = stim[i][1];
      id_uses_rs1     = stim[i][1];
      dmem_busy       = stim[i][0];
      #1;
      nvec++;
      if (obs !== exp[i]) begin nerr++; $display("FAIL branch[%0d]: got %b want %b", i, obs, exp[i]); end
      if (!exp[i][8]) exp_stall++;
      edge_step();
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back_div();
    logic [8:0] exp [0:10];
    exp = '{DIVS, DIVW, DIVW, DIVW, REL, DIVS, DIVW, DIVW, DIVW, REL, RUNR};
    for (int i = 0; i < 11; i++) begin
      ex_is_div = (i < 10);
      #1;
      nvec++;
      if (obs !== exp[i]) begin nerr++; $display("FAIL div[%0d]: got %b want %b", i, obs, exp[i]); end
      if (!exp[i][8]) exp_stall++;
      edge_step();
    end
    clear_inputs();
    nvec++;
    if (stall_cycles !== exp_sc()) begin nerr++; $display("FAIL div_stalls: got %0d want %0d", stall_cycles, exp_sc()); end
  endtask

  task automatic test_div_mem_wait();
    logic [8:0] exp [0:8];
    exp = '{DIVS, DIVW, FRZD, FRZD, FRZD, DIVW, DIVW, REL, RUNR};
    for (int i = 0; i < 9; i++) begin
      ex_is_div = (i == 0);
      dmem_busy = (i >= 2 && i <= 4);
      #1;
      nvec++;
      if (obs !== exp[i]) begin nerr++; $display("FAIL div_mem[%0d]: got %b want %b", i, obs, exp[i]); end
      if (!exp[i][8]) exp_stall++;
      edge_step();
    end
    clear_inputs();
    nvec++;
    if (mem_timeout !== 1'b0) begin nerr++; $display("FAIL div_mem_timeout: got %b want 0", mem_timeout); end
  endtask

  task automatic test_mem_timeout_and_reset();
    for (int i = 0; i < 8; i++) begin
      dmem_busy = 1'b1;
      ex_branch_taken = 1'b1;
      #1;
      nvec++;
      if ({obs, mem_timeout} !== {FRZ, 1'b0}) begin
        nerr++; $display("FAIL busy[%0d]: got %b/%b want %b/0", i, obs, mem_timeout, FRZ);
      end
      exp_stall++;
      edge_step();
    end
    nvec++;
    if (stall_cycles !== exp_sc()) begin nerr++; $display("FAIL busy_stalls: got %0d want %0d", stall_cycles, exp_sc()); end
    clear_inputs();
    ex_is_div = 1'b1;
    #1;
    nvec++;
    if ({obs, mem_timeout} !== {DIVS, 1'b1}) begin
      nerr++; $display("FAIL div_from_mem_wait: got %b/%b want %b/1", obs, mem_timeout, DIVS);
    end
    edge_step();
    #1;
    nvec++;
    if (obs !== DIVW) begin nerr++; $display("FAIL pre_reset_div: got %b want %b", obs, DIVW); end
    #1;
    reset = 1'b1;
    exp_stall = 0;
    #1;
    nvec++;
    if ({obs, mem_timeout} !== {RUNR, 1'b0}) begin
      nerr++; $display("FAIL mid_div_reset: got %b/%b want %b/0", obs, mem_timeout, RUNR);
    end
    nvec++;
    if (stall_cycles !== 32'd0) begin nerr++; $display("FAIL mid_div_reset_stalls: got %0d want 0", stall_cycles); end
    edge_step();
    reset = 1'b0;
    ex_is_div = 1'b0;
    #1;
    nvec++;
    if (obs !== RUNR) begin nerr++; $display("FAIL after_reset_row: got %b want %b", obs, RUNR); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_back_to_back_div();
    test_div_mem_wait();
    test_mem_timeout_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
